// File: rtl/imem_pkg.sv
// Shared types and address decode for the loadable RV32I instruction memory.
package imem_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic {
      CLEAR,
      RUN
   } state_e;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2
   } fault_e;

   typedef struct packed {
      fault_e      fault;
      logic [31:0] index;
   } decode_t;

   // off is the byte offset from the base address, zero-extended to 64 bits.
   // Misalignment is checked first so a misaligned out-of-range address reports misaligned.
   function automatic decode_t addr_decode(input logic [63:0] off, input int unsigned depth);
      decode_t d;
      d.index = off[33:2];
      if (off[1:0] != 2'b00) begin
         d.fault = FAULT_MISALIGN;
      end else if ({2'b00, off[63:2]} >= 64'(depth)) begin
         d.fault = FAULT_RANGE;
      end else begin
         d.fault = FAULT_NONE;
      end
      return d;
   endfunction

endpackage

// File: rtl/imem_sram_1rw.sv
// Single-port word array with registered read; read data holds until the next enabled read.
module imem_sram_1rw #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XLEN-1:0]          wdata,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with NOP-clear after reset, program-load port and a
// valid/ready fetch port backed by a one-entry response register.
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     DEPTH     = 64,
   parameter logic [XLEN-1:0] FILL_WORD = RV_NOP,
   parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_instr,
   output logic [1:0]      resp_fault,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [XLEN-1:0] load_addr,
   input  logic [XLEN-1:0] load_data,
   output logic            init_done
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            resp_valid_q, resp_valid_d;
   fault_e          resp_fault_q, resp_fault_d;

   logic [63:0]     req_off, load_off;
   decode_t         req_dec, load_dec;
   logic            run, fetch_accept;

   logic            mem_we, mem_re;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata, mem_rdata;

   always_comb begin
      req_off  = '0;
      load_off = '0;
      req_off[XLEN-1:0]  = req_addr - BASE_ADDR;
      load_off[XLEN-1:0] = load_addr - BASE_ADDR;
   end

   assign req_dec  = addr_decode(req_off, DEPTH);
   assign load_dec = addr_decode(load_off, DEPTH);

   logic unused_index_bits;
   assign unused_index_bits = ^{req_dec.index, load_dec.index};

   assign run          = (state_q == RUN);
   assign load_ready   = run;
   assign req_ready    = run && !load_valid && (!resp_valid_q || resp_ready);
   assign fetch_accept = req_valid && req_ready;

   // Single array port: clear writes, then loads, then fetch reads. Reset masks all access.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!reset) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = FILL_WORD;
         end else if (load_valid) begin
            if (load_dec.fault == FAULT_NONE) begin
               mem_we    = 1'b1;
               mem_addr  = load_dec.index[AW-1:0];
               mem_wdata = load_data;
            end
         end else if (fetch_accept && (req_dec.fault == FAULT_NONE)) begin
            mem_re   = 1'b1;
            mem_addr = req_dec.index[AW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_fault_d = resp_fault_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
         end
      end
      if (fetch_accept) begin
         resp_valid_d = 1'b1;
         resp_fault_d = req_dec.fault;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CLEAR;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= FAULT_NONE;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   imem_sram_1rw #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Array read data is only meaningful for a valid, non-faulted response.
   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_instr = (resp_valid_q && (resp_fault_q == FAULT_NONE)) ? mem_rdata : '0;
   assign init_done  = run;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: clear timing, loads, fetch faults,
// back-pressure, load/fetch arbitration and reset during activity.
module tb_imem_fetch_port;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [1:0]  resp_fault;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        init_done;

   int vectors     = 0;
   int miscompares = 0;

   imem_fetch_port #(
      .XLEN      (32),
      .DEPTH     (64),
      .FILL_WORD (32'h0000_0013),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_fault (resp_fault),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .init_done  (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_init;
      int cycles = 0;
      while (init_done !== 1'b1 && cycles < 200) begin
         chk("clear_req_ready", 32'(req_ready), 32'd0);
         chk("clear_load_ready", 32'(load_ready), 32'd0);
         tick();
         cycles++;
      end
      chk("init_cycles", cycles, 32'd64);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
      load_valid = 1'b1;
      load_addr  = addr;
      load_data  = data;
      #1;
      chk("load_ready", 32'(load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic fetch_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_instr, input logic [1:0] exp_fault);
      req_valid  = 1'b1;
      req_addr   = addr;
      resp_ready = 1'b1;
      #1;
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_instr"}, resp_instr, exp_instr);
      chk({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      load_valid = 1'b0;
      load_addr  = '0;
      load_data  = '0;

      tick();
      tick();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_instr", resp_instr, 32'd0);
      chk("rst_resp_fault", 32'(resp_fault), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);

      reset = 1'b0;
      wait_init();

      // Misaligned and out-of-range loads must not reach word 0.
      do_load(32'h0000_0001, 32'hFFFF_FFFF);
      do_load(32'h0000_0100, 32'hFFFF_FFFF);
      fetch_chk("nop0", 32'h0000_0000, 32'h0000_0013, 2'd0);
      fetch_chk("nop4", 32'h0000_0004, 32'h0000_0013, 2'd0);
      fetch_chk("nopFC", 32'h0000_00FC, 32'h0000_0013, 2'd0);

      // Loads then back-to-back fetches.
      do_load(32'h0000_0000, 32'h1234_52B7);
      do_load(32'h0000_0004, 32'h0000_1317);
      req_valid  = 1'b1;
      req_addr   = 32'h0000_0000;
      resp_ready = 1'b1;
      #1;
      tick();
      req_addr = 32'h0000_0004;
      #1;
      chk("b2b_first_valid", 32'(resp_valid), 32'd1);
      chk("b2b_first_instr", resp_instr, 32'h1234_52B7);
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      chk("b2b_second_valid", 32'(resp_valid), 32'd1);
      chk("b2b_second_instr", resp_instr, 32'h0000_1317);
      tick();
      chk("b2b_drain_valid", 32'(resp_valid), 32'd0);

      // Fault decode and precedence.
      fetch_chk("mis42", 32'h0000_0042, 32'h0, 2'd1);
      fetch_chk("rng100", 32'h0000_0100, 32'h0, 2'd2);
      fetch_chk("mis102", 32'h0000_0102, 32'h0, 2'd1);

      // Back-pressure: response held for three cycles, queued request waits.
      do_load(32'h0000_000C, 32'h00A0_0093);
      req_valid  = 1'b1;
      req_addr   = 32'h0000_0008;
      resp_ready = 1'b0;
      #1;
      tick();
      req_addr = 32'h0000_000C;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_instr", resp_instr, 32'h0000_0013);
         chk("hold_fault", 32'(resp_fault), 32'd0);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      chk("release_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      chk("release_valid", 32'(resp_valid), 32'd1);
      chk("release_instr", resp_instr, 32'h00A0_0093);
      tick();
      chk("release_drain", 32'(resp_valid), 32'd0);

      // Same-cycle load and fetch of the same word.
      load_valid = 1'b1;
      load_addr  = 32'h0000_0010;
      load_data  = 32'hDEAD_BEEF;
      req_valid  = 1'b1;
      req_addr   = 32'h0000_0010;
      resp_ready = 1'b1;
      #1;
      chk("arb_req_ready", 32'(req_ready), 32'd0);
      chk("arb_load_ready", 32'(load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      #1;
      chk("arb_stall_valid", 32'(resp_valid), 32'd0);
      chk("arb_req_ready2", 32'(req_ready), 32'd1);
      tick();
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      #1;
      chk("arb_resp_valid", 32'(resp_valid), 32'd1);
      chk("arb_resp_instr", resp_instr, 32'hDEAD_BEEF);

      // Reset with a response pending and a load in flight.
      load_valid = 1'b1;
      load_addr  = 32'h0000_0020;
      load_data  = 32'h1111_1111;
      #1;
      chk("pre_rst_valid", 32'(resp_valid), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_instr", resp_instr, 32'd0);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
      reset      = 1'b0;
      load_valid = 1'b0;
      wait_init();
      for (int i = 0; i < 64; i++) begin
         fetch_chk("refill", 32'(i * 4), 32'h0000_0013, 2'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
